vector_pe: RTL and testbench
============================

# vector_pe

Parametrised vector multiply-accumulate processing element. Each beat takes one full line of LANES signed neuron/weight pairs, not one pair per cycle. It reduces the line with a pipelined adder tree and accumulates the line sums across a multi-beat reduction framed by `ctl`. It sits between the neuron/weight line buffers and the result store, and it replaces the per-element serial PE for line-wide dot products.

## Interface
- `DATA_W`, 16, width of each signed neuron/weight element.
- `LANES`, 32, elements per line; a power of two, ≥2 (32×16 = 512-bit line).
- `ACC_W`, 32, accumulator/result width; must be ≥ 2*DATA_W.
- `clk`  in  1  clock; all logic rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `neuron`  in  LANES*DATA_W  neuron line; lane k at bits [k*DATA_W +: DATA_W].
- `weight`  in  LANES*DATA_W  weight line, same lane packing.
- `ctl`  in  2  frame control: 01 first, 00 middle, 10 last, 11 first+last (single-beat reduction).
- `vld_i`  in  1  beat valid; `neuron`, `weight` and `ctl` are sampled only when high.
- `result`  out  ACC_W  final accumulated dot product, two's complement.
- `vld_o`  out  1  one-cycle pulse when `result` is updated.

## Operation
- Stage M: registers the LANES signed products, each 2*DATA_W bits.
- Stages T1..Tn, n = clog2(LANES): registered binary adder tree.
  - Each level grows the sum by 1 bit; the full-precision sum is 2*DATA_W+n bits. No truncation inside the tree.
- Stage A: accumulator. The tree sum is sign-extended and added to the accumulator.
  - The `ctl` bits and `vld_i` travel down the pipeline alongside the data.
- Accumulator update, per beat reaching stage A:
  - first (01/11): acc = sum.
  - middle or last (00/10): acc = acc + sum.
  - last (10/11): `result` is loaded with the new acc and `vld_o` is pulsed.
- Bubbles: a beat with `vld_i`=0 is discarded at entry; acc, `result` and `vld_o` are unaffected.
- Non-last arithmetic: wraps modulo 2^ACC_W (see Configuration for overflow behaviour).
- `result` holds its value between pulses.
- No backpressure. One beat is accepted per cycle, and reductions may run back-to-back with no gap.
  - A first beat immediately after a last beat starts a fresh acc; the two reductions never mix.
- Middle/last beat with no preceding first beat since reset: accumulates onto the current acc (0 after reset). This is defined behaviour and is not flagged.
- Reset values: `result`=0, `vld_o`=0, acc=0, all pipeline valids=0.
- Reset asserted mid-reduction: in-flight beats are dropped and no `vld_o` is produced for them.

## Timing
- Latency L = 2 + clog2(LANES) cycles; L = 7 at the defaults.
  - A last beat sampled at edge t gives `vld_o`=1 and the new `result` in the cycle following edge t+L-1, i.e. registered at edge t+L-1.
- Throughput: 1 line per cycle.
- `vld_o` is exactly 1 cycle wide per last beat.
  - Two single-beat (11) reductions on consecutive cycles produce `vld_o` on consecutive cycles.
- `ctl` is ignored when `vld_i`=0.

## Configuration
- `VECTOR_PE_SAT_EN` defined: the stage-A sum (acc + sum, computed at full width) is clamped to the ACC_W signed range [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Once clamped, subsequent beats accumulate from the clamped value.
- Undefined: the low ACC_W bits are kept (wrap-around).
- The macro affects stage A only; latency is identical in both builds.

## Test plan
All scenarios use the defaults (DATA_W=16, LANES=32, ACC_W=32).
- Single beat, ctl=11, all neuron=0x0001, weight=0x0002 -> `result`=0x00000040, `vld_o` high for exactly 1 cycle, 7 cycles after sampling.
- 4-beat frame 01,00,00,10, neuron=0x0003, weight=0xFFFF -> `result`=0xFFFFFE80 (-384), one pulse.
- Same 4-beat frame with `vld_i` low for 3 cycles between each beat, and random `ctl`/data during the bubbles -> `result`=0xFFFFFE80, one pulse.
- Back-to-back frames, no gap:
  - frame A: 2 beats, neuron=1, weight=1.
  - frame B: 1 beat (11), neuron=2, weight=-1.
  - -> pulses with `result`=0x00000040, then 0xFFFFFFC0; B unaffected by A.
- Overflow, single beat ctl=11, neuron=weight=0x7FFF -> `result`=0xFFE00020 without `VECTOR_PE_SAT_EN`, and 0x7FFFFFFF with it.
- `rst_n` pulsed low mid-frame (after beat 2 of 4) -> `result`=0 and `vld_o`=0 immediately, no pulse for the aborted frame; a following 11 frame (neuron=1, weight=2) gives 0x00000040.

Source files
------------

// File: rtl/vector_pe.sv
// Line-wide signed multiply-accumulate PE: lane products, registered adder tree, framed accumulator.
// Define VECTOR_PE_SAT_EN to clamp the accumulator to the signed ACC_W range instead of wrapping.
module vector_pe #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LANES  = 32,
    parameter int unsigned ACC_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [LANES*DATA_W-1:0]   neuron,
    input  logic [LANES*DATA_W-1:0]   weight,
    input  logic [1:0]                ctl,
    input  logic                      vld_i,
    output logic [ACC_W-1:0]          result,
    output logic                      vld_o
);

    localparam int unsigned N      = $clog2(LANES);
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned SUM_W  = PROD_W + N;
    localparam int unsigned EXT_W  = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
    localparam int unsigned NODES  = 2 * LANES - 1;
    localparam int unsigned LEAF0  = LANES - 1;

    // Heap-ordered tree: leaves are the stage-M products, node 0 is the final line sum.
    logic signed [SUM_W-1:0]  node_d [NODES];
    logic signed [SUM_W-1:0]  node_q [NODES];
    logic signed [PROD_W-1:0] prod;

    logic [N:0] vld_pipe_d, vld_pipe_q;
    logic [1:0] ctl_pipe_d [N+1];
    logic [1:0] ctl_pipe_q [N+1];

    logic signed [ACC_W-1:0] acc_d, acc_q;
    logic [ACC_W-1:0]        result_d, result_q;
    logic                    vld_o_d, vld_o_q;
    logic signed [EXT_W-1:0] acc_base, acc_ext;
    logic signed [ACC_W-1:0] acc_new;

    always_comb begin
        prod = '0;
        for (int i = 0; i < NODES; i++) node_d[i] = node_q[i];
        // Leaves only load on a valid beat so idle cycles do not toggle the products.
        for (int k = 0; k < LANES; k++) begin
            prod = $signed(neuron[k*DATA_W +: DATA_W]) * $signed(weight[k*DATA_W +: DATA_W]);
            if (vld_i) node_d[LEAF0 + k] = SUM_W'(prod);
        end
        for (int i = 0; i < LEAF0; i++) node_d[i] = node_q[2*i+1] + node_q[2*i+2];
    end

    always_comb begin
        vld_pipe_d    = {vld_pipe_q[N-1:0], vld_i};
        ctl_pipe_d[0] = vld_i ? ctl : 2'b00;
        for (int j = 1; j <= N; j++) ctl_pipe_d[j] = ctl_pipe_q[j-1];
    end

    // Stage A: a first beat restarts from zero, every valid beat adds its line sum.
    always_comb begin
        acc_d    = acc_q;
        result_d = result_q;
        vld_o_d  = 1'b0;
        acc_base = ctl_pipe_q[N][0] ? '0 : EXT_W'(acc_q);
        acc_ext  = acc_base + EXT_W'(node_q[0]);
`ifdef VECTOR_PE_SAT_EN
        if (!(&acc_ext[EXT_W-1:ACC_W-1]) && (|acc_ext[EXT_W-1:ACC_W-1]))
            acc_new = acc_ext[EXT_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            acc_new = acc_ext[ACC_W-1:0];
`else
        acc_new = ACC_W'(acc_ext);
`endif
        if (vld_pipe_q[N]) begin
            acc_d = acc_new;
            if (ctl_pipe_q[N][1]) begin
                result_d = acc_new;
                vld_o_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NODES; i++) node_q[i] <= '0;
            for (int j = 0; j <= N; j++) ctl_pipe_q[j] <= 2'b00;
            vld_pipe_q <= '0;
            acc_q      <= '0;
            result_q   <= '0;
            vld_o_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NODES; i++) node_q[i] <= node_d[i];
            for (int j = 0; j <= N; j++) ctl_pipe_q[j] <= ctl_pipe_d[j];
            vld_pipe_q <= vld_pipe_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            vld_o_q    <= vld_o_d;
        end
    end

    assign result = result_q;
    assign vld_o  = vld_o_q;

endmodule

// File: tb/tb_vector_pe.sv
// Directed bench for vector_pe at default parameters; expected values are hand-computed.
// Expectations for overflow vectors follow VECTOR_PE_SAT_EN when it is defined.
module tb_vector_pe;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned LANES  = 32;
    localparam int unsigned ACC_W  = 32;
    localparam int          LAT    = 6;   // sampling edge to result edge

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [LANES*DATA_W-1:0] neuron = '0;
    logic [LANES*DATA_W-1:0] weight = '0;
    logic [1:0]              ctl = 2'b00;
    logic                    vld_i = 1'b0;
    logic [ACC_W-1:0]        result;
    logic                    vld_o;

    vector_pe #(.DATA_W(DATA_W), .LANES(LANES), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .neuron(neuron), .weight(weight),
        .ctl(ctl), .vld_i(vld_i), .result(result), .vld_o(vld_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int        pq_cyc [$];
    logic [31:0] pq_res [$];
    always @(negedge clk) if (rst_n && vld_o) begin
        pq_cyc.push_back(cyc);
        pq_res.push_back(result);
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic beat(input logic [15:0] n, input logic [15:0] w, input logic [1:0] c, output int t);
        @(negedge clk);
        neuron = {LANES{n}};
        weight = {LANES{w}};
        ctl    = c;
        vld_i  = 1'b1;
        t      = cyc + 1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            vld_i  = 1'b0;
            ctl    = 2'($urandom);
            for (int l = 0; l < LANES; l++) begin
                neuron[l*DATA_W +: DATA_W] = 16'($urandom);
                weight[l*DATA_W +: DATA_W] = 16'($urandom);
            end
        end
    endtask

    task automatic pop_check(input string name, input int t_exp, input logic [31:0] r_exp);
        int          t_got;
        logic [31:0] r_got;
        if (pq_cyc.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got no vld_o pulse expected one at cycle %0d", name, t_exp);
        end else begin
            t_got = pq_cyc.pop_front();
            r_got = pq_res.pop_front();
            chk({name, "_cycle"}, 32'(t_got), 32'(t_exp));
            chk({name, "_result"}, r_got, r_exp);
        end
    endtask

    task automatic no_more(input string name);
        chk({name, "_extra_pulses"}, 32'(pq_cyc.size()), 32'd0);
        pq_cyc.delete();
        pq_res.delete();
    endtask

    typedef struct {
        logic [15:0] n;
        logic [15:0] w;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [8];
    int   tt  [8];
    int   t0, t1, t2, t3;

    initial begin
        tbl[0] = '{16'h0001, 16'h0002, 32'h0000_0040};
        tbl[1] = '{16'h0003, 16'hFFFF, 32'hFFFF_FFA0};
        tbl[2] = '{16'h0000, 16'h1234, 32'h0000_0000};
        tbl[3] = '{16'hFFFF, 16'hFFFF, 32'h0000_0020};
        tbl[4] = '{16'h0064, 16'hFF9C, 32'hFFFB_1E00};
`ifdef VECTOR_PE_SAT_EN
        tbl[5] = '{16'h7FFF, 16'h7FFF, 32'h7FFF_FFFF};
        tbl[6] = '{16'h8000, 16'h8000, 32'h7FFF_FFFF};
        tbl[7] = '{16'h8000, 16'h7FFF, 32'h8000_0000};
`else
        tbl[5] = '{16'h7FFF, 16'h7FFF, 32'hFFE0_0020};
        tbl[6] = '{16'h8000, 16'h8000, 32'h0000_0000};
        tbl[7] = '{16'h8000, 16'h7FFF, 32'h0010_0000};
`endif

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_result", result, 32'h0);
        chk("reset_vld_o", 32'(vld_o), 32'h0);
        rst_n = 1'b1;
        idle(2);

        // Single-beat reductions issued back to back: pulses on consecutive cycles
        for (int i = 0; i < 8; i++) beat(tbl[i].n, tbl[i].w, 2'b11, tt[i]);
        idle(LAT + 4);
        for (int i = 0; i < 8; i++) pop_check($sformatf("single_%0d", i), tt[i] + LAT, tbl[i].exp);
        no_more("single");
        idle(3);
        chk("result_hold", result, tbl[7].exp);

        // 4-beat frame, contiguous
        beat(16'h0003, 16'hFFFF, 2'b01, t0);
        beat(16'h0003, 16'hFFFF, 2'b00, t0);
        beat(16'h0003, 16'hFFFF, 2'b00, t0);
        beat(16'h0003, 16'hFFFF, 2'b10, t0);
        idle(LAT + 3);
        pop_check("frame4", t0 + LAT, 32'hFFFF_FE80);
        no_more("frame4");

        // Same frame with 3-cycle bubbles carrying random ctl/data
        beat(16'h0003, 16'hFFFF, 2'b01, t0); idle(3);
        beat(16'h0003, 16'hFFFF, 2'b00, t0); idle(3);
        beat(16'h0003, 16'hFFFF, 2'b00, t0); idle(3);
        beat(16'h0003, 16'hFFFF, 2'b10, t0);
        idle(LAT + 3);
        pop_check("frame4_bubbles", t0 + LAT, 32'hFFFF_FE80);
        no_more("frame4_bubbles");

        // Back-to-back frames A (2 beats) and B (single beat)
        beat(16'h0001, 16'h0001, 2'b01, t0);
        beat(16'h0001, 16'h0001, 2'b10, t1);
        beat(16'h0002, 16'hFFFF, 2'b11, t2);
        idle(LAT + 3);
        pop_check("b2b_a", t1 + LAT, 32'h0000_0040);
        pop_check("b2b_b", t2 + LAT, 32'hFFFF_FFC0);
        no_more("b2b");

        // Overflowing first beat then a large negative last beat
        beat(16'h7FFF, 16'h7FFF, 2'b01, t0);
        beat(16'h8000, 16'h7FFF, 2'b10, t1);
        idle(LAT + 3);
`ifdef VECTOR_PE_SAT_EN
        pop_check("ovf_frame", t1 + LAT, 32'h8000_0000);
`else
        pop_check("ovf_frame", t1 + LAT, 32'hFFF0_0020);
`endif
        no_more("ovf_frame");

        // Reset mid-frame after beat 2 of 4
        beat(16'h0003, 16'hFFFF, 2'b01, t0);
        beat(16'h0003, 16'hFFFF, 2'b00, t0);
        @(negedge clk);
        vld_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_result", result, 32'h0);
        chk("midrst_vld_o", 32'(vld_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        beat(16'h0003, 16'hFFFF, 2'b00, t0);
        beat(16'h0003, 16'hFFFF, 2'b10, t3);
        idle(LAT + 3);
        pop_check("post_rst_orphan", t3 + LAT, 32'hFFFF_FF40);
        no_more("post_rst_orphan");
        beat(16'h0001, 16'h0002, 2'b11, t0);
        idle(LAT + 3);
        pop_check("post_rst_single", t0 + LAT, 32'h0000_0040);
        no_more("post_rst_single");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
